up_datapath_p: RTL
==================

// Module: up_datapath_p
// PURPOSE
//  Parametrised second-generation microprocessor datapath: register bank, ALU with status flags,
//  PC with increment/load, SP with checked push/pop, IR latch and memory-address mux.
//  Sits between the control FSM (drives all selects/enables) and memory (data_in/data_out/addr_out).
//  New vs first generation: generic width and register count, flags, PC auto-increment, stack bounds checks.
// PARAMETERS
//  DATA_W   8   datapath, register, PC and SP width (>=4)
//  REG_N    4   register-bank depth (power of 2, >=2); RSEL_W = $clog2(REG_N)
//  IR_W     4   instruction width latched from data_in[DATA_W-1 -: IR_W]
//  SP_TOP   {DATA_W{1'b1}}  SP reset value / empty-stack address
//  SP_BOT   0   lowest legal stack address
// PORTS
//  clk             in   1       rising-edge clock
//  nRst            in   1       asynchronous active-low reset
//  data_in         in   DATA_W  memory read data
//  a_sel_in_a      in   1       ALU A: 0=reg[rb_sel_out_a], 1=data_in
//  a_sel_in_b      in   1       ALU B: 0=reg[rb_sel_out_b], 1=PC
//  a_op            in   4       ALU operation
//  rb_sel_out_a    in   RSEL_W  read port A index
//  rb_sel_out_b    in   RSEL_W  read port B index
//  rb_sel_in       in   RSEL_W  write index
//  rb_sel_data_in  in   1       write data: 0=ALU result, 1=data_in
//  rb_we           in   1       register write enable
//  flags_we        in   1       update flags from ALU
//  ir_we           in   1       latch IR
//  pc_we           in   1       load PC from ALU result
//  pc_inc          in   1       PC <= PC+1
//  sp_op           in   2       00 hold, 01 push (dec), 10 pop (inc), 11 load from ALU result
//  addr_sel        in   2       addr_out: 00 PC, 01 SP, 10 ALU result, 11 reg[rb_sel_out_b]
//  data_out        out  DATA_W  reg[rb_sel_out_a] (memory write data)
//  addr_out        out  DATA_W  memory address per addr_sel
//  ir              out  IR_W    instruction register
//  flags           out  4       {N,V,C,Z}
//  stack_err       out  1       sticky stack overflow/underflow
// BEHAVIOUR
//  - Reset (async): regs, PC, IR, flags, stack_err = 0; SP = SP_TOP. Combinational outputs follow that state.
//  - Reads combinational; all state updates on rising clk; read-during-write returns OLD value.
//  - ALU ops 0..15: ADD, ADC, SUB(A-B), SBC(A-B-!C), AND, OR, XOR, NOT A, SHL, SHR, ROL(thru C),
//    ROR(thru C), PASS A, PASS B, INC A, DEC A. Result mod 2^DATA_W.
//  - C: carry-out for add/inc; NOT borrow for sub/dec (C=1 when A>=B); shifted-out bit for shifts/rotates;
//    0 for logic/pass. V: signed overflow for add/sub/inc/dec, else 0. Z: result==0. N: result MSB.
//  - Flags change only when flags_we=1; ADC/SBC/ROL/ROR use the registered C.
//  - pc_we and pc_inc together: pc_we wins. PC wraps all-ones -> 0 silently.
//  - Push with SP==SP_BOT or pop with SP==SP_TOP: SP holds, stack_err <= 1. Otherwise SP -/+ 1.
//    stack_err clears only on reset. sp_op=11 loads unchecked.
//  - addr_sel=01 presents SP before the same-cycle push/pop takes effect (push writes at SP then decrements).
//  - Concurrent rb_we, flags_we, ir_we, pc_*, sp_op are independent; all commit in the same edge.
//  - Reset mid-operation: all state returns to reset values immediately, no partial commit.
// STRUCTURE
//  - Shared include up_datapath_defs.vh: ALU opcode, sp_op and addr_sel localparams; flag bit indices.
//  - Sub-module up_alu_p (combinational, DATA_W param): A, B, op, c_in -> result, {N,V,C,Z}.
//  - Top holds register bank, PC, SP, IR, flags, stack_err and muxes.
// TESTING (DATA_W=8, REG_N=4)
//  1 Reset: after nRst low/high -> flags=0, ir=0, stack_err=0, addr_out(addr_sel=01)=8'hFF.
//  2 Load r1=8'hF0 and r2=8'h20 via data_in; ADD r1+r2 with flags_we -> r3=8'h10, C=1, Z=0, V=0; ADC same -> 8'h11.
//  3 SUB 8'h80-8'h01 -> 8'h7F, V=1, C=1, N=0; SUB 8'h01-8'h02 -> 8'hFF, C=0, N=1.
//  4 pc_inc x3 -> PC=3; pc_we+pc_inc with ALU=8'h40 -> PC=8'h40; PC=8'hFF then inc -> 8'h00.
//  5 Pop at reset SP -> stack_err=1, SP=8'hFF; reset; 255 pushes -> SP=0, next push -> stack_err=1, SP=0.
//  6 rb_we r1 while reading r1 on data_out -> old value that cycle, new next; reset mid-write -> r1=0.

Source files
------------

// File: rtl/up_datapath_p_pkg.sv
// Shared definitions for the up_datapath_p datapath: ALU opcodes, stack ops,
// address-mux selects and flag bit positions.
package up_datapath_p_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_ADC    = 4'd1,
    ALU_SUB    = 4'd2,
    ALU_SBC    = 4'd3,
    ALU_AND    = 4'd4,
    ALU_OR     = 4'd5,
    ALU_XOR    = 4'd6,
    ALU_NOT    = 4'd7,
    ALU_SHL    = 4'd8,
    ALU_SHR    = 4'd9,
    ALU_ROL    = 4'd10,
    ALU_ROR    = 4'd11,
    ALU_PASS_A = 4'd12,
    ALU_PASS_B = 4'd13,
    ALU_INC    = 4'd14,
    ALU_DEC    = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    SP_HOLD = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_LOAD = 2'b11
  } sp_op_e;

  typedef enum logic [1:0] {
    ADDR_PC    = 2'b00,
    ADDR_SP    = 2'b01,
    ADDR_ALU   = 2'b10,
    ADDR_REG_B = 2'b11
  } addr_sel_e;

  // Flag vector layout is {N,V,C,Z}.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/up_datapath_p_alu.sv
// Combinational ALU for up_datapath_p: sixteen operations, result plus {N,V,C,Z}.
// C is carry-out for additions and NOT-borrow for subtractions.
module up_alu_p
  import up_datapath_p_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] wide;
  logic            carry;
  logic            ovf;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      ALU_ADD, ALU_ADC: begin
        wide   = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, (op == ALU_ADC) & c_in};
        result = wide[MSB:0];
        carry  = wide[DATA_W];
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_SUB, ALU_SBC: begin
        // The extra top bit becomes 1 on borrow; C reports its inverse.
        wide   = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, (op == ALU_SBC) & ~c_in};
        result = wide[MSB:0];
        carry  = ~wide[DATA_W];
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_NOT:    result = ~a;
      ALU_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        carry  = a[MSB];
      end
      ALU_SHR: begin
        result = {1'b0, a[MSB:1]};
        carry  = a[0];
      end
      ALU_ROL: begin
        result = {a[MSB-1:0], c_in};
        carry  = a[MSB];
      end
      ALU_ROR: begin
        result = {c_in, a[MSB:1]};
        carry  = a[0];
      end
      ALU_PASS_A: result = a;
      ALU_PASS_B: result = b;
      ALU_INC: begin
        wide   = {1'b0, a} + (DATA_W + 1)'(1);
        result = wide[MSB:0];
        carry  = wide[DATA_W];
        ovf    = ~a[MSB] & result[MSB];
      end
      ALU_DEC: begin
        wide   = {1'b0, a} - (DATA_W + 1)'(1);
        result = wide[MSB:0];
        carry  = ~wide[DATA_W];
        ovf    = a[MSB] & ~result[MSB];
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[MSB];
    flags[FLAG_V] = ovf;
    flags[FLAG_C] = carry;
    flags[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/up_datapath_p.sv
// Second-generation microprocessor datapath: register bank, ALU with flags,
// PC with increment/load, bounds-checked SP, IR latch and memory-address mux.
module up_datapath_p
  import up_datapath_p_pkg::*;
#(
  parameter int              DATA_W = 8,
  parameter int              REG_N  = 4,
  parameter int              IR_W   = 4,
  parameter logic [DATA_W-1:0] SP_TOP = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0] SP_BOT = '0,
  localparam int             RSEL_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              a_sel_in_a,
  input  logic              a_sel_in_b,
  input  logic [3:0]        a_op,
  input  logic [RSEL_W-1:0] rb_sel_out_a,
  input  logic [RSEL_W-1:0] rb_sel_out_b,
  input  logic [RSEL_W-1:0] rb_sel_in,
  input  logic              rb_sel_data_in,
  input  logic              rb_we,
  input  logic              flags_we,
  input  logic              ir_we,
  input  logic              pc_we,
  input  logic              pc_inc,
  input  logic [1:0]        sp_op,
  input  logic [1:0]        addr_sel,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] addr_out,
  output logic [IR_W-1:0]   ir,
  output logic [3:0]        flags,
  output logic              stack_err
);

  logic [DATA_W-1:0] regs [REG_N];
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] sp;

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;

  assign rd_a     = regs[rb_sel_out_a];
  assign rd_b     = regs[rb_sel_out_b];
  assign alu_a    = a_sel_in_a ? data_in : rd_a;
  assign alu_b    = a_sel_in_b ? pc : rd_b;
  assign data_out = rd_a;

  up_alu_p #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op_e'(a_op)),
    .c_in   (flags[FLAG_C]),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // NOTE: the bank is built from flops and is architecturally cleared at reset,
  // so every entry is reset here rather than left to a RAM macro.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (rb_we) begin
      regs[rb_sel_in] <= rb_sel_data_in ? data_in : alu_result;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values; same-cycle reads therefore see the old contents.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pc    <= '0;
      ir    <= '0;
      flags <= '0;
    end else begin
      if (pc_we)       pc <= alu_result;
      else if (pc_inc) pc <= pc + DATA_W'(1);
      if (ir_we)       ir <= data_in[DATA_W-1 -: IR_W];
      if (flags_we)    flags <= alu_flags;
    end
  end

  // Out-of-range push/pop leaves SP untouched and latches the sticky error.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sp        <= SP_TOP;
      stack_err <= 1'b0;
    end else begin
      unique case (sp_op_e'(sp_op))
        SP_PUSH: begin
          if (sp == SP_BOT) stack_err <= 1'b1;
          else              sp <= sp - DATA_W'(1);
        end
        SP_POP: begin
          if (sp == SP_TOP) stack_err <= 1'b1;
          else              sp <= sp + DATA_W'(1);
        end
        SP_LOAD: sp <= alu_result;
        default: sp <= sp;
      endcase
    end
  end

  always_comb begin
    addr_out = pc;
    unique case (addr_sel_e'(addr_sel))
      ADDR_PC:    addr_out = pc;
      ADDR_SP:    addr_out = sp;
      ADDR_ALU:   addr_out = alu_result;
      ADDR_REG_B: addr_out = rd_b;
      default:    addr_out = pc;
    endcase
  end

endmodule
